// File: rtl/proc_out_fifo.sv
// proc_out_fifo: buffers processed words, which arrive with no backpressure, and replays each frame on a valid/ready stream.
// Latency: a pushed word appears on m_data one cycle after wr when it is the head (FWFT); occupancy is visible on level the same cycle.
// Backpressure: m_ready only stalls the output side; a push while full is dropped and raises the sticky ovf flag.
// Optional feature: define POF_OVF_CNT_EN to add a saturating 16-bit ovf_cnt output that counts dropped pushes.
module proc_out_fifo #(
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   frame_start,
    input  logic [31:0]            frame_words,
    input  logic                   wr,
    input  logic [DW-1:0]          data_fifo,
    output logic                   m_valid,
    output logic [DW-1:0]          m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   ovf,
    output logic                   frame_done
`ifdef POF_OVF_CNT_EN
   ,output logic [15:0]            ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);

    // Frame sequencing states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [1:0]    state_q,  state_d;
    logic [31:0]   frame_words_q, frame_words_d;
    logic [31:0]   out_cnt_q, out_cnt_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic push_ok;
    logic drop;
    logic pop;
    logic last_word;

    // Handshake qualifiers. A full FIFO drops the push even when a pop frees a slot in the same cycle.
    always_comb begin
        full      = (level_q == FULL_LVL);
        push_ok   = wr && !full;
        drop      = wr && full;
        m_valid   = (state_q == ST_STREAM) && (level_q != '0);
        // With a zero-length frame no word is ever tagged last, so the stream never completes by itself.
        last_word = (frame_words_q != 32'd0) && (out_cnt_q == (frame_words_q - 32'd1));
        m_last    = m_valid && last_word;
        pop       = m_valid && m_ready;
    end

    // Output views of the registered state.
    always_comb begin
        m_data      = mem_q[rd_ptr_q];
        level       = level_q;
        almost_full = (level_q >= AF_LVL);
        ovf         = ovf_q;
        frame_done  = (state_q == ST_DONE);
    end

    // Pointer and occupancy update. clear wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Frame FSM: arm on frame_start, stream until the last word pops, pulse frame_done, rearm.
    always_comb begin
        state_d       = state_q;
        frame_words_d = frame_words_q;
        out_cnt_d     = out_cnt_q;
        if (clear) begin
            state_d       = ST_IDLE;
            frame_words_d = 32'd0;
            out_cnt_d     = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        frame_words_d = frame_words;
                        out_cnt_d     = 32'd0;
                        state_d       = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // A new frame_start is ignored while the current frame is still in flight.
                    if (pop) begin
                        out_cnt_d = out_cnt_q + 32'd1;
                        if (last_word) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Words already buffered for the next frame stay in the FIFO.
                    out_cnt_d = 32'd0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    out_cnt_d = 32'd0;
                end
            endcase
        end
    end

    // Sticky overflow flag; only reset or clear removes it.
    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Storage write; the array carries no reset since pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem_q[wr_ptr_q] <= data_fifo;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            state_q       <= ST_IDLE;
            frame_words_q <= 32'd0;
            out_cnt_q     <= 32'd0;
            ovf_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            state_q       <= state_d;
            frame_words_q <= frame_words_d;
            out_cnt_q     <= out_cnt_d;
            ovf_q         <= ovf_d;
        end
    end

`ifdef POF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Dropped-push counter, saturating so it never wraps back to a small value.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear) begin
            ovf_cnt_d = 16'd0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Dropped-push counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 16'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
